// File: rtl/ov7670_stream_tx_pkg.sv
// Shared types for the OV7670-style stream transmitter and its capture peer.
// Holds the FSM state encoding and the RGB444 two-byte wire order.
package ov7670_stream_tx_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_VSYNC  = 3'd1,
    STATE_VBACK  = 3'd2,
    STATE_ACTIVE = 3'd3,
    STATE_VFRONT = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Wire order: even byte carries {0, B}, odd byte carries {G, R}.
  function automatic logic [BYTE_W-1:0] rgb444_byte(input rgb444_t pix, input logic odd);
    return odd ? {pix.g, pix.r} : {4'h0, pix.b};
  endfunction

endpackage

// File: rtl/ov7670_stream_tx_if.sv
// Camera-side parallel bus plus the pixel RAM read port feeding it.
interface ov7670_stream_tx_if;
  import ov7670_stream_tx_pkg::*;

  logic              PCLK;
  logic              VSYNC;
  logic              HREF;
  logic [BYTE_W-1:0] DATA;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [PIX_W-1:0]  RD_DATA;

  modport master (
    output PCLK, VSYNC, HREF, DATA, RD_ADDR,
    input  RD_DATA
  );

  modport slave (
    input  PCLK, VSYNC, HREF, DATA, RD_ADDR,
    output RD_DATA
  );

endinterface

// File: rtl/ov7670_timing_gen.sv
// Frame timing for the stream transmitter: PCLK phase, period/line counters,
// frame FSM, sync outputs and the strobes that steer address and byte muxing.
module ov7670_timing_gen
  import ov7670_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = 176,
  parameter int unsigned HEIGHT      = 144,
  parameter int unsigned HBLANK      = 16,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 2,
  parameter int unsigned VFP_LINES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              tick_c,
  output logic              pclk,
  output logic              href,
  output logic              vsync,
  output logic              frame_done,
  output logic              frame_start_c,
  output logic              row_load_c,
  output logic              first_row_c,
  output logic              pix_load_c,
  output logic [ADDR_W-1:0] fetch_x_c,
  output logic              byte_even_c,
  output logic              byte_odd_c
);

  localparam int unsigned LINE_LEN    = 2 * WIDTH + HBLANK;
  localparam int unsigned FRAME_LINES = VSYNC_LINES + VBP_LINES + HEIGHT + VFP_LINES;
  localparam int unsigned PCNT_W      = $clog2(LINE_LEN);
  localparam int unsigned LINE_W      = $clog2(FRAME_LINES);

  state_e            state_q, state_d, after_state_c;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [LINE_W-1:0] line_q, line_d, last_line_c;
  logic              phase_q, phase_d;
  logic              href_q, href_d;
  logic              vsync_q, vsync_d;
  logic              done_q, done_d;
  logic              href_nxt_c;

  assign tick_c = phase_q;

  // State register: phase runs freely, everything else moves on ticks only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_IDLE;
      pcnt_q  <= '0;
      line_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      line_q  <= line_d;
      phase_q <= phase_d;
    end
  end

  // Next state: period counter wraps per line, lines counted within each state.
  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    line_d        = line_q;
    phase_d       = ~phase_q;
    last_line_c   = '0;
    after_state_c = STATE_IDLE;
    case (state_q)
      STATE_VSYNC: begin
        last_line_c   = LINE_W'(VSYNC_LINES - 1);
        after_state_c = STATE_VBACK;
      end
      STATE_VBACK: begin
        last_line_c   = LINE_W'(VBP_LINES - 1);
        after_state_c = STATE_ACTIVE;
      end
      STATE_ACTIVE: begin
        last_line_c   = LINE_W'(HEIGHT - 1);
        after_state_c = STATE_VFRONT;
      end
      STATE_VFRONT: begin
        last_line_c   = LINE_W'(VFP_LINES - 1);
        after_state_c = enable ? STATE_VSYNC : STATE_IDLE;
      end
      default: ;
    endcase
    if (tick_c) begin
      if (state_q == STATE_IDLE) begin
        if (enable) state_d = STATE_VSYNC;
      end else if (pcnt_q == PCNT_W'(LINE_LEN - 1)) begin
        pcnt_d = '0;
        if (line_q == last_line_c) begin
          line_d  = '0;
          state_d = after_state_c;
        end else begin
          line_d = line_q + LINE_W'(1);
        end
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
    end
  end

  // Outputs and strobes describe the period that the current tick starts.
  always_comb begin
    href_nxt_c    = (state_d == STATE_ACTIVE) && (pcnt_d < PCNT_W'(2 * WIDTH));
    href_d        = href_nxt_c;
    vsync_d       = (state_d == STATE_VSYNC);
    done_d        = tick_c && (state_q == STATE_VFRONT) && (state_d != STATE_VFRONT);
    frame_start_c = tick_c && (state_q != STATE_VSYNC) && (state_d == STATE_VSYNC);
    row_load_c    = tick_c && (pcnt_d == PCNT_W'(LINE_LEN - 1)) &&
                    (((state_d == STATE_VBACK) && (line_d == LINE_W'(VBP_LINES - 1))) ||
                     ((state_d == STATE_ACTIVE) && (line_d != LINE_W'(HEIGHT - 1))));
    first_row_c   = (state_d == STATE_VBACK);
    pix_load_c    = tick_c && (state_d == STATE_ACTIVE) && pcnt_d[0] &&
                    (pcnt_d < PCNT_W'(2 * WIDTH - 1));
    fetch_x_c     = ADDR_W'((pcnt_d + PCNT_W'(1)) >> 1);
    byte_even_c   = tick_c && href_nxt_c && !pcnt_d[0];
    byte_odd_c    = tick_c && href_nxt_c && pcnt_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      href_q  <= href_d;
      vsync_q <= vsync_d;
      done_q  <= done_d;
    end
  end

  assign pclk       = phase_q;
  assign href       = href_q;
  assign vsync      = vsync_q;
  assign frame_done = done_q;

endmodule

// File: rtl/ov7670_stream_tx.sv
// OV7670-style RGB444 stream source: timing generator plus RAM address
// generator, pixel register and two-byte-per-pixel output mux.
module ov7670_stream_tx
  import ov7670_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = 176,
  parameter int unsigned HEIGHT      = 144,
  parameter int unsigned HBLANK      = 16,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 2,
  parameter int unsigned VFP_LINES   = 2
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               ENABLE,
  output logic               FRAME_DONE,
  ov7670_stream_tx_if.master cam
);

  logic              tick_c, pclk, href, vsync, frame_done;
  logic              frame_start_c, row_load_c, first_row_c, pix_load_c;
  logic              byte_even_c, byte_odd_c;
  logic [ADDR_W-1:0] fetch_x_c;

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  rgb444_t           pix_q, pix_d;
  logic [BYTE_W-1:0] data_q, data_d;

  ov7670_timing_gen #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .HBLANK     (HBLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .VBP_LINES  (VBP_LINES),
    .VFP_LINES  (VFP_LINES)
  ) u_timing (
    .clk          (CLOCK),
    .rst          (RESET),
    .enable       (ENABLE),
    .tick_c       (tick_c),
    .pclk         (pclk),
    .href         (href),
    .vsync        (vsync),
    .frame_done   (frame_done),
    .frame_start_c(frame_start_c),
    .row_load_c   (row_load_c),
    .first_row_c  (first_row_c),
    .pix_load_c   (pix_load_c),
    .fetch_x_c    (fetch_x_c),
    .byte_even_c  (byte_even_c),
    .byte_odd_c   (byte_odd_c)
  );

  // Address runs one RAM latency plus one PCLK phase ahead of the even byte.
  always_comb begin
    row_base_d = row_base_q;
    rd_addr_d  = rd_addr_q;
    pix_d      = pix_q;
    data_d     = data_q;
    if (frame_start_c) begin
      row_base_d = '0;
      rd_addr_d  = '0;
    end
    if (row_load_c) begin
      row_base_d = first_row_c ? '0 : row_base_q + ADDR_W'(WIDTH);
      rd_addr_d  = row_base_d;
    end
    if (pix_load_c) begin
      rd_addr_d = row_base_q + fetch_x_c;
    end
    if (tick_c) begin
      data_d = '0;
    end
    if (byte_even_c) begin
      pix_d  = rgb444_t'(cam.RD_DATA);
      data_d = rgb444_byte(pix_d, 1'b0);
    end
    if (byte_odd_c) begin
      data_d = rgb444_byte(pix_q, 1'b1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      row_base_q <= '0;
      rd_addr_q  <= '0;
      pix_q      <= '0;
      data_q     <= '0;
    end else begin
      row_base_q <= row_base_d;
      rd_addr_q  <= rd_addr_d;
      pix_q      <= pix_d;
      data_q     <= data_d;
    end
  end

  assign cam.PCLK    = pclk;
  assign cam.VSYNC   = vsync;
  assign cam.HREF    = href;
  assign cam.DATA    = data_q;
  assign cam.RD_ADDR = rd_addr_q;
  assign FRAME_DONE  = frame_done;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Self-checking bench for ov7670_stream_tx: a frame-level model predicts
// VSYNC/HREF/DATA for every PCLK period from a RAM image filled by $urandom.
module tb_ov7670_stream_tx;

  localparam int TW    = 8;
  localparam int TH    = 6;
  localparam int THB   = 4;
  localparam int TVS   = 3;
  localparam int TVBP  = 2;
  localparam int TVFP  = 2;
  localparam int LINE  = 2 * TW + THB;
  localparam int FLEN  = (TVS + TVBP + TH + TVFP) * LINE;
  localparam int NPIX  = TW * TH;
  localparam int WBUDG = 4 * FLEN;

  logic CLOCK = 1'b0;
  logic RESET;
  logic ENABLE;
  logic FRAME_DONE;

  ov7670_stream_tx_if cam ();

  ov7670_stream_tx #(
    .WIDTH      (TW),
    .HEIGHT     (TH),
    .HBLANK     (THB),
    .VSYNC_LINES(TVS),
    .VBP_LINES  (TVBP),
    .VFP_LINES  (TVFP)
  ) u_dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .FRAME_DONE(FRAME_DONE),
    .cam       (cam)
  );

  always #5 CLOCK = ~CLOCK;

  logic [11:0] mem [NPIX];

  // Registered RAM, one CLOCK of read latency.
  always @(posedge CLOCK)
    cam.RD_DATA <= (int'(cam.RD_ADDR) < NPIX) ? mem[int'(cam.RD_ADDR)] : 12'h000;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {vsync, href, data} expected in PCLK period k of a frame.
  function automatic logic [9:0] exp_at(input int k);
    int          line, p, y;
    logic        vs, hr;
    logic [7:0]  d;
    logic [11:0] px;
    line = k / LINE;
    p    = k % LINE;
    y    = line - TVS - TVBP;
    vs   = (line < TVS);
    hr   = (y >= 0) && (y < TH) && (p < 2 * TW);
    d    = 8'h00;
    if (hr) begin
      px = mem[y * TW + p / 2];
      d  = (p % 2 == 0) ? {4'h0, px[3:0]} : {px[7:4], px[11:8]};
    end
    return {vs, hr, d};
  endfunction

  logic rst_at_edge = 1'b1;
  logic pclk_prev   = 1'b0;
  logic href_prev   = 1'b0;
  logic done_due    = 1'b0;
  bit   in_frame    = 1'b0;
  int   k = 0, rows = 0;
  int   frames_started = 0, frames_done = 0, done_seen = 0, pclk_rises = 0;

  always @(posedge CLOCK) rst_at_edge = RESET;

  // Monitor: samples on the falling CLOCK edge, acts on PCLK rising periods.
  always @(negedge CLOCK) begin
    logic [9:0] e;
    if (rst_at_edge) begin
      in_frame  = 1'b0;
      done_due  = 1'b0;
      pclk_prev = 1'b0;
    end else begin
      chk("pclk_toggle", cam.PCLK, !pclk_prev);
      if (FRAME_DONE || done_due) chk("frame_done", FRAME_DONE, done_due);
      if (FRAME_DONE) done_seen++;
      done_due = 1'b0;
      if (cam.PCLK && !pclk_prev) begin
        pclk_rises++;
        if (!in_frame && cam.VSYNC) begin
          in_frame  = 1'b1;
          k         = 0;
          rows      = 0;
          href_prev = 1'b0;
          frames_started++;
          chk("start_enable", ENABLE, 1'b1);
        end
        if (in_frame) begin
          e = exp_at(k);
          chk("vsync", cam.VSYNC, e[9]);
          chk("href", cam.HREF, e[8]);
          chk("data", cam.DATA, e[7:0]);
          if (cam.HREF && !href_prev) rows++;
          href_prev = cam.HREF;
          if (k == FLEN - 1) begin
            chk("href_rows", rows, TH);
            frames_done++;
            in_frame = 1'b0;
            done_due = 1'b1;
          end else begin
            k++;
          end
        end else begin
          chk("idle_href", cam.HREF, 1'b0);
          chk("idle_data", cam.DATA, 8'h00);
        end
      end
      pclk_prev = cam.PCLK;
    end
  end

  task automatic wait_start(input int target);
    int n = 0;
    while (frames_started < target && n < 16) begin
      @(negedge CLOCK);
      n++;
    end
    chk("wait_start", frames_started >= target, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < WBUDG) begin
      @(negedge CLOCK);
      n++;
    end
    chk("wait_done", frames_done >= target, 1'b1);
  endtask

  task automatic wait_k(input int frame, input int kmin);
    int n = 0;
    while (!(frames_started >= frame && in_frame && k >= kmin) && n < WBUDG) begin
      @(negedge CLOCK);
      n++;
    end
    chk("wait_k", n < WBUDG, 1'b1);
  endtask

  initial begin
    int r0, st;
    RESET  = 1'b1;
    ENABLE = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'(i);
    repeat (3) @(negedge CLOCK);
    chk("rst_pclk", cam.PCLK, 1'b0);
    chk("rst_vsync", cam.VSYNC, 1'b0);
    chk("rst_href", cam.HREF, 1'b0);
    chk("rst_data", cam.DATA, 8'h00);
    chk("rst_addr", cam.RD_ADDR, 15'd0);
    chk("rst_done", FRAME_DONE, 1'b0);
    RESET = 1'b0;

    repeat (12) @(negedge CLOCK);
    chk("idle_vsync", cam.VSYNC, 1'b0);
    chk("idle_frames", frames_started, 0);

    // Identity image, back-to-back frames, then ENABLE dropped mid-active.
    ENABLE = 1'b1;
    wait_start(1);
    wait_done(2);
    wait_k(3, (TVS + TVBP + TH / 2) * LINE + $urandom_range(0, LINE - 1));
    ENABLE = 1'b0;
    wait_done(3);
    r0 = pclk_rises;
    repeat (4 * LINE) @(negedge CLOCK);
    chk("stop_frames", frames_started, 3);
    chk("stop_vsync", cam.VSYNC, 1'b0);
    chk("hold_addr", cam.RD_ADDR, 15'(NPIX - 1));
    chk("idle_pclk", (pclk_rises - r0) >= 2 * LINE - 1, 1'b1);
    chk("done_count", done_seen, 3);

    // Random images with a reset landing somewhere in the active region.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
      st     = frames_started;
      ENABLE = 1'b1;
      wait_start(st + 1);
      wait_k(st + 1, (TVS + TVBP) * LINE + $urandom_range(0, TH * LINE - 1));
      RESET = 1'b1;
      @(negedge CLOCK);
      chk("mid_rst_vsync", cam.VSYNC, 1'b0);
      chk("mid_rst_href", cam.HREF, 1'b0);
      chk("mid_rst_data", cam.DATA, 8'h00);
      chk("mid_rst_addr", cam.RD_ADDR, 15'd0);
      chk("mid_rst_pclk", cam.PCLK, 1'b0);
      RESET = 1'b0;
      st = frames_done;
      wait_done(st + 1);
      repeat (4) @(negedge CLOCK);
      ENABLE = 1'b0;
      wait_done(st + 2);
      repeat (4) @(negedge CLOCK);
      chk("end_vsync", cam.VSYNC, 1'b0);
    end
    chk("done_total", done_seen, frames_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
